// File: rtl/ps2_scan_parser.sv
// ---------------------------------------------------------------------------
// ps2_scan_parser
//
// Turns the raw PS/2 Set 2 byte stream from ps2_rx into complete key events.
// The prefixes 0xE0 (extended) and 0xF0 (break) are folded into flags on the
// event. Events are presented one at a time through a valid/ack handshake.
// If a prefix sequence is left hanging for too long, a timeout returns the
// parser to IDLE.
//
// Handshake: key_valid rises when an event is loaded and stays high until the
// consumer pulses key_ack. key_code/key_ext/key_brk are stable for as long as
// key_valid is high. If key_ack and a new event arrive in the same cycle, the
// new event is loaded and key_valid stays high. If an event arrives while
// key_valid is high and there is no ack, that event is dropped and the sticky
// overrun flag is set.
//
// Parameters:
//   TIMEOUT_CYCLES - clk cycles a partial prefix sequence may wait for its
//                    next byte before the parser returns to IDLE.
//
// Optional feature:
//   PS2_TYPEMATIC_FILTER_EN - when defined, repeated makes of the key that is
//                             currently held are suppressed.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   rx_done_tick in   one-cycle strobe, din valid
//   din          in   [7:0] received byte
//   key_ack      in   consumer took the current event
//   key_valid    out  event pending
//   key_code     out  [7:0] final scan code byte
//   key_ext      out  event was preceded by 0xE0
//   key_brk      out  event is a release (preceded by 0xF0)
//   overrun      out  sticky: an event was dropped
//   dbg_state    out  [1:0] current FSM state (IDLE=0, GOT_E0=1, GOT_F0=2,
//                     GOT_E0F0=3)
// ---------------------------------------------------------------------------
module ps2_scan_parser #(
    parameter int TIMEOUT_CYCLES = 5000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_done_tick,
    input  logic [7:0] din,
    input  logic       key_ack,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_brk,
    output logic       overrun,
    output logic [1:0] dbg_state
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GOT_E0   = 2'd1,
        GOT_F0   = 2'd2,
        GOT_E0F0 = 2'd3
    } state_t;

    state_t        state, state_next, base_state;
    logic [CW-1:0] cnt, cnt_next;
    logic          timeout_fire;
    logic          is_ctrl;
    logic          emit;        // a complete event was parsed this cycle
    logic          emit_ext;
    logic          emit_brk;
    logic          emit_final;  // event after the typematic filter
    logic          load;        // event is written to the output registers

    // Keyboard control/response bytes that never form part of a key event.
    always_comb begin
        is_ctrl = 1'b0;
        case (din)
            8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFE, 8'hFF: is_ctrl = 1'b1;
            default: is_ctrl = 1'b0;
        endcase
    end

    // ---------------------------------------------------------------------
    // Next-state logic. The timeout is applied first, so a byte arriving in
    // the same cycle the timeout fires is parsed from IDLE.
    // ---------------------------------------------------------------------
    always_comb begin
        timeout_fire = (state != IDLE) && (cnt == CNT_MAX);
        base_state   = timeout_fire ? IDLE : state;
        state_next   = base_state;
        emit         = 1'b0;
        emit_ext     = 1'b0;
        emit_brk     = 1'b0;

        if (rx_done_tick) begin
            if (is_ctrl) begin
                state_next = IDLE;
            end else if (din == 8'hE0) begin
                case (base_state)
                    IDLE:     state_next = GOT_E0;
                    GOT_E0:   state_next = GOT_E0;
                    GOT_F0:   state_next = GOT_E0F0;
                    GOT_E0F0: state_next = GOT_E0F0;
                    default:  state_next = IDLE;
                endcase
            end else if (din == 8'hF0) begin
                case (base_state)
                    IDLE:     state_next = GOT_F0;
                    GOT_E0:   state_next = GOT_E0F0;
                    GOT_F0:   state_next = GOT_F0;
                    GOT_E0F0: state_next = GOT_E0F0;
                    default:  state_next = IDLE;
                endcase
            end else begin
                emit       = 1'b1;
                emit_ext   = (base_state == GOT_E0) || (base_state == GOT_E0F0);
                emit_brk   = (base_state == GOT_F0) || (base_state == GOT_E0F0);
                state_next = IDLE;
            end
        end

        // Counter measures idle time since the last byte of a partial
        // sequence; it never runs in IDLE.
        if (rx_done_tick || timeout_fire || (state == IDLE)) begin
            cnt_next = '0;
        end else begin
            cnt_next = cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    assign dbg_state = state;

`ifdef PS2_TYPEMATIC_FILTER_EN
    // ---------------------------------------------------------------------
    // Typematic filter: remembers the last make that reached the outputs.
    // Repeats of that make are swallowed silently (no overrun either), and
    // its break releases the hold so the next press is reported again.
    // ---------------------------------------------------------------------
    logic [8:0] hold_key;
    logic       hold_valid;
    logic       hold_match;

    assign hold_match = hold_valid && (hold_key == {emit_ext, din});
    assign emit_final = emit && !(!emit_brk && hold_match);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_key   <= '0;
            hold_valid <= 1'b0;
        end else if (load && !emit_brk) begin
            hold_key   <= {emit_ext, din};
            hold_valid <= 1'b1;
        end else if (emit && emit_brk && hold_match) begin
            hold_valid <= 1'b0;
        end
    end
`else
    assign emit_final = emit;
`endif

    // ---------------------------------------------------------------------
    // Output event registers and handshake.
    // ---------------------------------------------------------------------
    assign load = emit_final && (!key_valid || key_ack);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_valid <= 1'b0;
            key_code  <= 8'h00;
            key_ext   <= 1'b0;
            key_brk   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (load) begin
                key_valid <= 1'b1;
                key_code  <= din;
                key_ext   <= emit_ext;
                key_brk   <= emit_brk;
            end else if (emit_final) begin
                // Consumer still holds the previous event: drop this one.
                overrun   <= 1'b1;
            end else if (key_ack && key_valid) begin
                key_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/ps2_scan_parser.md
# ps2_scan_parser

Converts the raw byte stream from `ps2_rx` into complete key events by resolving the PS/2 Set 2 prefixes 0xE0 (extended) and 0xF0 (break). Sits directly downstream of `ps2_rx`: it consumes `dout`/`rx_done_tick` and presents one event at a time (code, extended, break) to the decoding stage through a valid/ack handshake. A prefix timeout recovers the parser from truncated sequences.

## Interface

- `TIMEOUT_CYCLES`, default 5000000 — `clk` cycles a partial prefix sequence may wait for its next byte; 100 ms at 50 MHz.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rx_done_tick`  in  1  one-cycle strobe from `ps2_rx`; `din` valid in this cycle.
- `din`  in  8  received byte from `ps2_rx`.
- `key_ack`  in  1  consumer has taken the current event.
- `key_valid`  out  1  event pending on outputs; held until acked.
- `key_code`  out  8  final (non-prefix) scan code byte.
- `key_ext`  out  1  event was preceded by 0xE0.
- `key_brk`  out  1  event is a release (preceded by 0xF0).
- `overrun`  out  1  sticky: an event was dropped because `key_valid` was still high.

## Operation

- Reset (`reset`=0, asynchronous): state IDLE, timeout counter 0, `key_valid`=0, `key_code`=0x00, `key_ext`=0, `key_brk`=0, `overrun`=0, typematic hold register cleared.
- Bytes are processed only in cycles with `rx_done_tick`=1; `din` is ignored otherwise.
- FSM states: IDLE, GOT_E0, GOT_F0, GOT_E0F0.
  - IDLE: 0xE0 -> GOT_E0; 0xF0 -> GOT_F0; other -> emit (ext=0, brk=0).
  - GOT_E0: 0xF0 -> GOT_E0F0; 0xE0 -> stay; other -> emit (ext=1, brk=0), IDLE.
  - GOT_F0: 0xF0 -> stay; 0xE0 -> GOT_E0F0; other -> emit (ext=0, brk=1), IDLE.
  - GOT_E0F0: 0xE0/0xF0 -> stay; other -> emit (ext=1, brk=1), IDLE.
- Control bytes 0x00, 0xAA, 0xE1, 0xEE, 0xFA, 0xFE, 0xFF: in any state, no event is emitted and the FSM returns to IDLE. Pause-key sequences are out of scope.
- Emit: if `key_valid`=0, or `key_ack`=1 in the same cycle, load `key_code`/`key_ext`/`key_brk` and set `key_valid`=1. Otherwise drop the event, leave the outputs unchanged and set `overrun`=1.
- `key_ack` with `key_valid`=1 and no simultaneous emit: `key_valid` goes to 0. The outputs hold their last values. `key_ack` with `key_valid`=0 is ignored.
- `overrun` clears only on reset.
- Timeout: the counter clears on every `rx_done_tick` and increments each cycle while state ≠ IDLE. When it reaches `TIMEOUT_CYCLES`-1, the FSM returns to IDLE and the counter clears. No event and no flag are produced. Counter width is $clog2(`TIMEOUT_CYCLES`). In IDLE the counter stays 0.

## Timing

- Latency: event byte strobed in cycle N produces `key_valid`=1 and stable outputs in cycle N+1 (registered outputs, no combinational path from `din` to outputs).
- Prefix bytes change state at cycle N+1 and produce no output change.
- Ack in cycle M drops `key_valid` in cycle M+1. Ack and emit in the same cycle: `key_valid` stays 1 and the outputs show the new event at M+1.
- Byte arriving in the same cycle the timeout fires: the byte is processed from IDLE, so the timeout is applied first.
- Reset asserted mid-sequence: all state is lost immediately, and the next byte is parsed from IDLE.

## Configuration

- `PS2_TYPEMATIC_FILTER_EN` defined: a 9-bit hold register {ext, code} plus a hold-valid bit tracks the last emitted make.
  - A make matching the held key is suppressed: no emit and no overrun.
  - A different make is emitted and replaces the hold.
  - A break matching the hold clears it.
  - Breaks are always emitted.
- `PS2_TYPEMATIC_FILTER_EN` undefined: every make, including typematic repeats, is emitted. The hold logic is not instantiated.

## Test plan

- Plain make/break: bytes 0x1C, then ack, then 0xF0 0x1C -> events {0x1C, ext=0, brk=0}, then {0x1C, ext=0, brk=1}. Each `key_valid` rises one cycle after the final byte's tick.
- Extended: 0xE0 0x75, ack, 0xE0 0xF0 0x75 -> {0x75, ext=1, brk=0}, then {0x75, ext=1, brk=1}.
- Overrun: 0x1C, then 0x32 with no ack -> outputs still 0x1C and `overrun`=1. Ack in the same cycle as a 0x32 tick -> 0x32 loaded, `key_valid` stays 1.
- Timeout: `TIMEOUT_CYCLES`=16, byte 0xE0 followed by 20 idle cycles, then 0x1C -> event {0x1C, ext=0, brk=0}. 0xF0 followed by 0x1C after 10 cycles -> a break.
- Control bytes and reset: 0xF0 0xAA 0x1C -> make 0x1C (break discarded). `reset` low while in GOT_E0F0 -> all outputs 0 asynchronously, and the next 0x29 gives {0x29, ext=0, brk=0}.
- Filter: 0x1C 0x1C 0x1C 0xF0 0x1C 0x1C, acking each event.
  - With `PS2_TYPEMATIC_FILTER_EN`: events are make, break, make.
  - Without it: events are make ×3, break, make.
